// File: rtl/event_latency_tracker.sv
// event_latency_tracker: per-ID start/end latency measurement.
// A scoreboard keeps a valid flag and start timestamp per ID; each matched end
// (or timeout retirement) produces a record that is queued in a small FIFO and
// handed downstream with a valid/ready handshake.
// Optional feature: define EVT_TIMEOUT_EN to compile in the timeout scanner that
// retires IDs left open for TIMEOUT_CYC cycles or more.
module event_latency_tracker #(
    parameter int unsigned ID_W        = 4,
    parameter int unsigned TS_W        = 64,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [ID_W-1:0] start_id,
    input  logic            end_valid,
    output logic            end_ready,
    input  logic [ID_W-1:0] end_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [TS_W-1:0] out_start_ts,
    output logic [TS_W-1:0] out_end_ts,
    output logic [TS_W-1:0] out_delta,
    output logic            out_timeout,
    output logic [ID_W:0]   active_count,
    output logic [15:0]     orphan_cnt
);

    localparam int unsigned DEPTH  = 2 ** ID_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ACT_W  = ID_W + 1;
    localparam int unsigned ORPH_W = 16;
`ifdef EVT_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // Record payload carried through the output FIFO
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] start_ts;
        logic [TS_W-1:0] end_ts;
        logic [TS_W-1:0] delta;
`ifdef EVT_TIMEOUT_EN
        logic            timeout;
`endif
    } rec_t;

    // Elaboration-time parameter sanity
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_check
        $error("event_latency_tracker: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_EN && ($clog2(TIMEOUT_CYC + 1) > TS_W)) begin : g_timeout_check
        $warning("event_latency_tracker: TIMEOUT_CYC exceeds the timestamp range");
    end

    // State
    logic [TS_W-1:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TS_W-1:0]   start_ts_q [DEPTH];
    logic [TS_W-1:0]   start_ts_d [DEPTH];
    rec_t              fifo_q [FIFO_DEPTH];
    rec_t              fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [ORPH_W-1:0] orphan_q, orphan_d;
    logic [ACT_W-1:0]  active_q, active_d;

    // Combinational decode
    logic fifo_full_c;
    logic end_ready_c;
    logic end_fire_c;
    logic end_hit_c;
    logic start_ready_c;
    logic start_fire_c;
    logic pop_c;
    logic push_c;
    rec_t push_rec_c;
    rec_t head_c;

    // Handshake decode; an end owns its ID for the cycle, so a same-ID start waits
    always_comb begin
        fifo_full_c   = (occ_q == CNT_W'(FIFO_DEPTH));
        end_ready_c   = !rst && !fifo_full_c;
        end_fire_c    = end_valid && end_ready_c;
        end_hit_c     = end_fire_c && valid_q[end_id];
        start_ready_c = !rst && !valid_q[start_id] && !(end_fire_c && (end_id == start_id));
        start_fire_c  = start_valid && start_ready_c;
        pop_c         = (occ_q != '0) && out_ready;
    end

`ifdef EVT_TIMEOUT_EN
    logic [ID_W-1:0] scan_ptr_q, scan_ptr_d;
    logic [TS_W-1:0] scan_age_c;
    logic            scan_due_c;
    logic            retire_c;

    // Age check of the ID under the scan pointer; the pointer waits on a blocked retirement
    always_comb begin
        scan_age_c = cnt_q - start_ts_q[scan_ptr_q];
        scan_due_c = valid_q[scan_ptr_q] && (scan_age_c >= TS_W'(TIMEOUT_CYC));
        retire_c   = scan_due_c && !end_fire_c && !start_fire_c && !fifo_full_c;
        scan_ptr_d = (scan_due_c && !retire_c) ? scan_ptr_q : scan_ptr_q + ID_W'(1);
    end

    // Scan pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr_q <= '0;
        end else begin
            scan_ptr_q <= scan_ptr_d;
        end
    end
`endif

    // Scoreboard update, record formation and counters
    always_comb begin
        cnt_d      = cnt_q + TS_W'(1);
        valid_d    = valid_q;
        start_ts_d = start_ts_q;
        orphan_d   = orphan_q;
        active_d   = active_q;
        push_c     = 1'b0;
        push_rec_c = '0;

        if (end_hit_c) begin
            valid_d[end_id]     = 1'b0;
            push_c              = 1'b1;
            push_rec_c.id       = end_id;
            push_rec_c.start_ts = start_ts_q[end_id];
            push_rec_c.end_ts   = cnt_q;
            push_rec_c.delta    = cnt_q - start_ts_q[end_id];
            active_d            = active_d - ACT_W'(1);
        end else if (end_fire_c && (orphan_q != '1)) begin
            orphan_d = orphan_q + ORPH_W'(1);
        end

`ifdef EVT_TIMEOUT_EN
        // Mutually exclusive with an end or start in the same cycle
        if (retire_c) begin
            valid_d[scan_ptr_q] = 1'b0;
            push_c              = 1'b1;
            push_rec_c.id       = scan_ptr_q;
            push_rec_c.start_ts = start_ts_q[scan_ptr_q];
            push_rec_c.end_ts   = cnt_q;
            push_rec_c.delta    = scan_age_c;
            push_rec_c.timeout  = 1'b1;
            active_d            = active_d - ACT_W'(1);
        end
`endif

        if (start_fire_c) begin
            valid_d[start_id]    = 1'b1;
            start_ts_d[start_id] = cnt_q;
            active_d             = active_d + ACT_W'(1);
        end
    end

    // Output record FIFO; space freed by a pop is only visible next cycle
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            fifo_d[wr_ptr_q] = push_rec_c;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Control and FIFO registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            valid_q  <= '0;
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            orphan_q <= '0;
            active_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            orphan_q <= orphan_d;
            active_q <= active_d;
        end
    end

    // Start timestamps need no reset: they are only read behind a set valid flag
    always_ff @(posedge clk) begin
        start_ts_q <= start_ts_d;
    end

    // Port drive; everything is forced low while reset is asserted
    always_comb begin
        head_c       = fifo_q[rd_ptr_q];
        start_ready  = start_ready_c;
        end_ready    = end_ready_c;
        out_valid    = !rst && (occ_q != '0);
        out_id       = rst ? '0 : head_c.id;
        out_start_ts = rst ? '0 : head_c.start_ts;
        out_end_ts   = rst ? '0 : head_c.end_ts;
        out_delta    = rst ? '0 : head_c.delta;
`ifdef EVT_TIMEOUT_EN
        out_timeout  = rst ? 1'b0 : head_c.timeout;
`else
        out_timeout  = 1'b0;
`endif
        active_count = rst ? '0 : active_q;
        orphan_cnt   = rst ? '0 : orphan_q;
    end

endmodule

// File: tb/tb_event_latency_tracker.sv
// Bench for event_latency_tracker: directed scenarios plus a randomized run
// against a queue-based reference model driven by absolute cycle counts.
module tb_event_latency_tracker;

    localparam int unsigned ID_W       = 4;
    localparam int unsigned TS_W       = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned ACT_W      = ID_W + 1;
    localparam int unsigned TO_CYC     = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (TS_W = 16)
    logic            rst, start_valid, end_valid, out_ready;
    logic [ID_W-1:0] start_id, end_id;
    logic            start_ready, end_ready, out_valid, out_timeout;
    logic [ID_W-1:0] out_id;
    logic [TS_W-1:0] out_start_ts, out_end_ts, out_delta;
    logic [ID_W:0]   active_count;
    logic [15:0]     orphan_cnt;

    event_latency_tracker #(.ID_W(ID_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_id(start_id),
        .end_valid(end_valid), .end_ready(end_ready), .end_id(end_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_delta(out_delta),
        .out_timeout(out_timeout), .active_count(active_count), .orphan_cnt(orphan_cnt)
    );

    // Narrow-timestamp instance (TS_W = 8) for wrap-around
    logic            w_rst, w_start_valid, w_end_valid, w_out_ready;
    logic [ID_W-1:0] w_start_id, w_end_id;
    logic            w_start_ready, w_end_ready, w_out_valid, w_out_timeout;
    logic [ID_W-1:0] w_out_id;
    logic [7:0]      w_out_start_ts, w_out_end_ts, w_out_delta;
    logic [ID_W:0]   w_active_count;
    logic [15:0]     w_orphan_cnt;

    event_latency_tracker #(.ID_W(ID_W), .TS_W(8), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TO_CYC)) dut_w (
        .clk(clk), .rst(w_rst),
        .start_valid(w_start_valid), .start_ready(w_start_ready), .start_id(w_start_id),
        .end_valid(w_end_valid), .end_ready(w_end_ready), .end_id(w_end_id),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_id(w_out_id),
        .out_start_ts(w_out_start_ts), .out_end_ts(w_out_end_ts), .out_delta(w_out_delta),
        .out_timeout(w_out_timeout), .active_count(w_active_count), .orphan_cnt(w_orphan_cnt)
    );

    // Reference model: open set, absolute start cycles, expected record queue
    typedef struct {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] sts;
        logic [TS_W-1:0] ets;
        logic [TS_W-1:0] dl;
    } exp_rec_t;

    exp_rec_t    exp_q[$];
    bit          m_open  [DEPTH];
    int unsigned m_start [DEPTH];
    int unsigned m_cnt;
    int unsigned m_orph;
    int          total = 0;
    int          bad   = 0;

    function automatic bit m_end_ready();
        return !rst && (exp_q.size() < FIFO_DEPTH);
    endfunction

    function automatic bit m_start_ready();
        return !rst && !m_open[start_id] && !(end_valid && m_end_ready() && (end_id == start_id));
    endfunction

    function automatic int m_active();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_open[i]);
        return n;
    endfunction

    // Advance one clock and apply the same transaction rules to the model
    task automatic tick();
        bit ef, sf, pop;
        logic [ID_W-1:0] eid, sid;
        exp_rec_t r;
        ef  = end_valid && m_end_ready();
        sf  = start_valid && m_start_ready();
        pop = !rst && (exp_q.size() != 0) && out_ready;
        eid = end_id;
        sid = start_id;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) m_open[i] = 1'b0;
            m_cnt  = 0;
            m_orph = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (ef) begin
                if (m_open[eid]) begin
                    m_open[eid] = 1'b0;
                    r.id  = eid;
                    r.sts = TS_W'(m_start[eid]);
                    r.ets = TS_W'(m_cnt);
                    r.dl  = TS_W'(m_cnt - m_start[eid]);
                    exp_q.push_back(r);
                end else if (m_orph < 65535) begin
                    m_orph++;
                end
            end
            if (sf) begin
                m_open[sid]  = 1'b1;
                m_start[sid] = m_cnt;
            end
            m_cnt++;
        end
        #1;
    endtask

    task automatic set_idle();
        start_valid = 1'b0; start_id = '0;
        end_valid   = 1'b0; end_id   = '0;
        out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b1; start_id = 4'd5; end_valid = 1'b1; end_id = 4'd5; out_ready = 1'b1;
        #1;
        total++;
        if ({start_ready, end_ready, out_valid, out_timeout, out_id, out_start_ts, out_end_ts, out_delta, active_count, orphan_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs_first got sr=%b er=%b ov=%b ac=%0d oc=%0d exp all 0", start_ready, end_ready, out_valid, active_count, orphan_cnt);
        end
        tick();
        tick();
        total++;
        if ({start_ready, end_ready, out_valid, out_timeout, out_id, out_start_ts, out_end_ts, out_delta, active_count, orphan_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs_held got sr=%b er=%b ov=%b ac=%0d oc=%0d exp all 0", start_ready, end_ready, out_valid, active_count, orphan_cnt);
        end
        do_reset();
        #1;
        total++;
        if ({end_ready, out_valid, active_count, orphan_cnt} !== {1'b1, 1'b0, ACT_W'(0), 16'd0}) begin
            bad++; $display("FAIL reset_release got er=%b ov=%b ac=%0d oc=%0d exp er=1 ov=0 ac=0 oc=0", end_ready, out_valid, active_count, orphan_cnt);
        end
    endtask

    task automatic test_basic();
        do_reset();
        while (m_cnt != 10) tick();
        start_valid = 1'b1; start_id = 4'd3; #1;
        total++;
        if (start_ready !== 1'b1) begin bad++; $display("FAIL basic_start_ready got %b exp 1", start_ready); end
        tick();
        start_valid = 1'b0;
        while (m_cnt != 25) tick();
        end_valid = 1'b1; end_id = 4'd3; #1;
        total++;
        if ({end_ready, out_valid, active_count} !== {1'b1, 1'b0, ACT_W'(1)}) begin
            bad++; $display("FAIL basic_end_cycle got er=%b ov=%b ac=%0d exp er=1 ov=0 ac=1", end_ready, out_valid, active_count);
        end
        tick();
        end_valid = 1'b0; #1;
        total++;
        if ({out_valid, out_id, out_start_ts, out_end_ts, out_delta, out_timeout} !== {1'b1, 4'd3, 16'd10, 16'd25, 16'd15, 1'b0}) begin
            bad++; $display("FAIL basic_record got v=%b id=%0d s=%0d e=%0d d=%0d t=%b exp v=1 id=3 s=10 e=25 d=15 t=0", out_valid, out_id, out_start_ts, out_end_ts, out_delta, out_timeout);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; #1;
        total++;
        if ({out_valid, active_count} !== {1'b0, ACT_W'(0)}) begin
            bad++; $display("FAIL basic_after_pop got ov=%b ac=%0d exp ov=0 ac=0", out_valid, active_count);
        end
    endtask

    task automatic test_wrap();
        int wc;
        w_start_valid = 1'b0; w_end_valid = 1'b0; w_out_ready = 1'b0; w_start_id = '0; w_end_id = '0;
        w_rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        w_rst = 1'b0;
        wc = 0;
        while (wc != 250) begin @(posedge clk); #1; wc++; end
        w_start_valid = 1'b1; w_start_id = 4'd1; #1;
        total++;
        if (w_start_ready !== 1'b1) begin bad++; $display("FAIL wrap_start_ready got %b exp 1", w_start_ready); end
        @(posedge clk); #1; wc++;
        w_start_valid = 1'b0;
        while (wc != 261) begin @(posedge clk); #1; wc++; end
        w_end_valid = 1'b1; w_end_id = 4'd1;
        @(posedge clk); #1;
        w_end_valid = 1'b0; #1;
        total++;
        if ({w_out_valid, w_out_id, w_out_start_ts, w_out_end_ts, w_out_delta} !== {1'b1, 4'd1, 8'd250, 8'd5, 8'd11}) begin
            bad++; $display("FAIL wrap_record got v=%b id=%0d s=%0d e=%0d d=%0d exp v=1 id=1 s=250 e=5 d=11", w_out_valid, w_out_id, w_out_start_ts, w_out_end_ts, w_out_delta);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1; start_id = ID_W'(i);
            tick();
        end
        start_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            end_valid = 1'b1; end_id = ID_W'(i); #1;
            total++;
            if (end_ready !== (i < 4)) begin bad++; $display("FAIL bp_end_ready id=%0d got %b exp %b", i, end_ready, (i < 4)); end
            if (i < 4) tick();
        end
        out_ready = 1'b1; #1;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({out_valid, out_id} !== {1'b1, ID_W'(k)}) begin
                bad++; $display("FAIL bp_order slot=%0d got v=%b id=%0d exp v=1 id=%0d", k, out_valid, out_id, k);
            end
            if (k < 2) begin
                total++;
                if (end_ready !== (k == 1)) begin bad++; $display("FAIL bp_pending_end slot=%0d got er=%b exp %b", k, end_ready, (k == 1)); end
            end
            tick();
            if (k == 1) end_valid = 1'b0;
        end
        #1;
        total++;
        if ({out_valid, active_count} !== {1'b0, ACT_W'(0)}) begin
            bad++; $display("FAIL bp_drained got ov=%b ac=%0d exp ov=0 ac=0", out_valid, active_count);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        out_ready = 1'b1;
        start_valid = 1'b1; start_id = 4'd7;
        tick();
        start_valid = 1'b0; #1;
        total++;
        if (active_count !== ACT_W'(1)) begin bad++; $display("FAIL same_open_count got %0d exp 1", active_count); end
        end_valid = 1'b1; end_id = 4'd7; start_valid = 1'b1; start_id = 4'd7; #1;
        total++;
        if ({end_ready, start_ready} !== 2'b10) begin bad++; $display("FAIL same_priority got er=%b sr=%b exp er=1 sr=0", end_ready, start_ready); end
        tick();
        end_valid = 1'b0; #1;
        total++;
        if ({start_ready, out_valid, out_id, active_count} !== {1'b1, 1'b1, 4'd7, ACT_W'(0)}) begin
            bad++; $display("FAIL same_next got sr=%b ov=%b id=%0d ac=%0d exp sr=1 ov=1 id=7 ac=0", start_ready, out_valid, out_id, active_count);
        end
        tick();
        start_valid = 1'b0; #1;
        total++;
        if ({out_valid, active_count} !== {1'b0, ACT_W'(1)}) begin
            bad++; $display("FAIL same_after got ov=%b ac=%0d exp ov=0 ac=1", out_valid, active_count);
        end
    endtask

    task automatic test_orphan();
        do_reset();
        end_valid = 1'b1; end_id = 4'd9; #1;
        total++;
        if (end_ready !== 1'b1) begin bad++; $display("FAIL orphan_end_ready got %b exp 1", end_ready); end
        tick();
        end_valid = 1'b0; #1;
        total++;
        if ({out_valid, orphan_cnt, active_count} !== {1'b0, 16'd1, ACT_W'(0)}) begin
            bad++; $display("FAIL orphan_result got ov=%b oc=%0d ac=%0d exp ov=0 oc=1 ac=0", out_valid, orphan_cnt, active_count);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        for (int i = 1; i < 4; i++) begin start_valid = 1'b1; start_id = ID_W'(i); tick(); end
        start_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin end_valid = 1'b1; end_id = ID_W'(i); tick(); end
        end_valid = 1'b0;
        rst = 1'b1; #1;
        total++;
        if ({out_valid, active_count, end_ready, start_ready} !== '0) begin
            bad++; $display("FAIL midrst_during got ov=%b ac=%0d er=%b sr=%b exp 0", out_valid, active_count, end_ready, start_ready);
        end
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;
        start_id = 4'd3; #1;
        total++;
        if ({start_ready, active_count} !== {1'b1, ACT_W'(0)}) begin
            bad++; $display("FAIL midrst_cleared got sr=%b ac=%0d exp sr=1 ac=0", start_ready, active_count);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin if (out_valid) seen++; tick(); end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL midrst_no_records got %0d records exp 0", seen); end
    endtask

    task automatic test_random();
        exp_rec_t e;
        do_reset();
        for (int c = 0; c < 90; c++) begin
            start_valid = ($urandom_range(0, 99) < 50);
            start_id    = ID_W'($urandom_range(0, 7));
            end_valid   = ($urandom_range(0, 99) < 45);
            end_id      = ID_W'($urandom_range(0, 7));
            out_ready   = ($urandom_range(0, 99) < 55);
            #1;
            total++;
            if ({start_ready, end_ready} !== {m_start_ready(), m_end_ready()}) begin
                bad++; $display("FAIL rand_ready cyc=%0d got sr=%b er=%b exp sr=%b er=%b", c, start_ready, end_ready, m_start_ready(), m_end_ready());
            end
            total++;
            if (out_valid !== (exp_q.size() != 0)) begin
                bad++; $display("FAIL rand_out_valid cyc=%0d got %b exp %b", c, out_valid, (exp_q.size() != 0));
            end else if (exp_q.size() != 0) begin
                e = exp_q[0];
                total++;
                if ({out_id, out_start_ts, out_end_ts, out_delta, out_timeout} !== {e.id, e.sts, e.ets, e.dl, 1'b0}) begin
                    bad++; $display("FAIL rand_record cyc=%0d got id=%0d s=%0d e=%0d d=%0d t=%b exp id=%0d s=%0d e=%0d d=%0d t=0", c, out_id, out_start_ts, out_end_ts, out_delta, out_timeout, e.id, e.sts, e.ets, e.dl);
                end
            end
            total++;
            if ({active_count, orphan_cnt} !== {ACT_W'(m_active()), 16'(m_orph)}) begin
                bad++; $display("FAIL rand_counts cyc=%0d got ac=%0d oc=%0d exp ac=%0d oc=%0d", c, active_count, orphan_cnt, m_active(), m_orph);
            end
            tick();
        end
        set_idle();
    endtask

`ifdef EVT_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit found;
        do_reset();
        start_valid = 1'b1; start_id = 4'd2;
        tick();
        start_valid = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            if (out_valid) found = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL timeout_wait no record within 300 cycles");
        end else begin
            total++;
            if ({out_id, out_timeout, active_count} !== {4'd2, 1'b1, ACT_W'(0)}) begin
                bad++; $display("FAIL timeout_record got id=%0d t=%b ac=%0d exp id=2 t=1 ac=0", out_id, out_timeout, active_count);
            end
            total++;
            if (out_delta < 16'(TO_CYC) || out_delta > 16'(TO_CYC + DEPTH) || TS_W'(out_end_ts - out_start_ts) !== out_delta) begin
                bad++; $display("FAIL timeout_delta got d=%0d s=%0d e=%0d exp %0d..%0d", out_delta, out_start_ts, out_end_ts, TO_CYC, TO_CYC + DEPTH);
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        int seen;
        do_reset();
        out_ready = 1'b1;
        start_valid = 1'b1; start_id = 4'd2;
        tick();
        start_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (out_valid || out_timeout) seen++;
            @(posedge clk);
        end
        #1;
        total++;
        if ({seen, active_count} !== {32'd0, ACT_W'(1)}) begin
            bad++; $display("FAIL no_timeout got records=%0d ac=%0d exp records=0 ac=1", seen, active_count);
        end
    endtask
`endif

    initial begin
        w_rst = 1'b1;
        w_start_valid = 1'b0; w_end_valid = 1'b0; w_out_ready = 1'b0;
        w_start_id = '0; w_end_id = '0;
        set_idle();
        test_reset();
        test_basic();
        test_backpressure();
        test_same_cycle();
        test_orphan();
        test_reset_mid();
        test_random();
`ifdef EVT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
